// File: rtl/mmm_pkg.sv
// Shared core types: machine width, PC offset, BTB resolution record and the
// branch queue entry holding one in-flight prediction.
package mmm_pkg;

  localparam int XLEN   = 32;
  localparam int OFFSET = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } resolution_t;

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic                   taken;
    logic [XLEN-OFFSET-1:0] target;
  } bq_entry_t;

endpackage

// File: rtl/branch_queue_if.sv
// Fetch/execute-facing signals of the branch queue; the queue uses the slave side.
interface branch_queue_if #(parameter int DEPTH_BITS = 3);
  import mmm_pkg::*;

  // pred_valid_i pushes when !full_o and exe_valid_i pops when !empty_o, both at
  // the rising clock edge; neither side ever stalls, rejected requests are dropped.
  logic                   flush_i;
  logic                   pred_valid_i;
  logic [XLEN-1:0]        pred_pc_i;
  logic                   pred_taken_i;
  logic [XLEN-OFFSET-1:0] pred_target_i;
  logic                   exe_valid_i;
  logic                   exe_taken_i;
  logic [XLEN-1:0]        exe_target_i;
  logic                   full_o;
  logic                   empty_o;
  logic [DEPTH_BITS:0]    count_o;
  logic                   btb_valid_o;
  logic                   btb_del_entry_o;
  resolution_t            btb_res_o;
  logic                   mispredict_o;
  logic [XLEN-1:0]        redirect_pc_o;
  logic                   underflow_o;

  modport master (
    output flush_i, pred_valid_i, pred_pc_i, pred_taken_i, pred_target_i,
           exe_valid_i, exe_taken_i, exe_target_i,
    input  full_o, empty_o, count_o, btb_valid_o, btb_del_entry_o, btb_res_o,
           mispredict_o, redirect_pc_o, underflow_o
  );

  modport slave (
    input  flush_i, pred_valid_i, pred_pc_i, pred_taken_i, pred_target_i,
           exe_valid_i, exe_taken_i, exe_target_i,
    output full_o, empty_o, count_o, btb_valid_o, btb_del_entry_o, btb_res_o,
           mispredict_o, redirect_pc_o, underflow_o
  );

endinterface

// File: rtl/branch_queue.sv
// In-order queue of branch predictions; each resolution from execute is compared
// against the oldest prediction to produce BTB updates and mispredict redirects.
module branch_queue
  import mmm_pkg::*;
#(
  parameter int DEPTH_BITS = 3
) (
  input logic          clk_i,
  input logic          rst_i,
  branch_queue_if.slave bq
);

  localparam int                  DEPTH      = 2 ** DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_COUNT = (DEPTH_BITS + 1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] COUNT_ONE  = (DEPTH_BITS + 1)'(1);
  localparam logic [DEPTH_BITS-1:0] PTR_ONE  = DEPTH_BITS'(1);

  bq_entry_t             mem [DEPTH];
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS:0]   count;

  bq_entry_t head;
  logic      full;
  logic      empty;
  logic      do_push;
  logic      do_pop;
  logic      mispred;

  assign full       = (count == FULL_COUNT);
  assign empty      = (count == '0);
  assign bq.full_o  = full;
  assign bq.empty_o = empty;
  assign bq.count_o = count;

  always_comb begin
    head    = mem[rd_ptr];
    do_push = bq.pred_valid_i && !full;
    do_pop  = bq.exe_valid_i && !empty;
    // Target only matters when both sides agree the branch is taken.
    mispred = (head.taken != bq.exe_taken_i) ||
              (head.taken && bq.exe_taken_i &&
               (head.target != bq.exe_target_i[XLEN-1:OFFSET]));
  end

  // Storage needs no reset; an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= '{pc: bq.pred_pc_i, taken: bq.pred_taken_i, target: bq.pred_target_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || bq.flush_i) begin
      rd_ptr             <= '0;
      wr_ptr             <= '0;
      count              <= '0;
      bq.btb_valid_o     <= 1'b0;
      bq.btb_del_entry_o <= 1'b0;
      bq.btb_res_o       <= '0;
      bq.mispredict_o    <= 1'b0;
      bq.redirect_pc_o   <= '0;
      bq.underflow_o     <= 1'b0;
    end else begin
      bq.btb_valid_o     <= 1'b0;
      bq.btb_del_entry_o <= 1'b0;
      bq.btb_res_o       <= '0;
      bq.mispredict_o    <= 1'b0;
      bq.redirect_pc_o   <= '0;
      bq.underflow_o     <= bq.exe_valid_i && empty;

      if (do_pop) begin
        if (bq.exe_taken_i) begin
          bq.btb_valid_o <= 1'b1;
          bq.btb_res_o   <= '{pc: head.pc, target: bq.exe_target_i};
        end else if (head.taken) begin
          bq.btb_valid_o     <= 1'b1;
          bq.btb_del_entry_o <= 1'b1;
          bq.btb_res_o       <= '{pc: head.pc, target: '0};
        end
        if (mispred) begin
          bq.mispredict_o  <= 1'b1;
          bq.redirect_pc_o <= bq.exe_taken_i ? bq.exe_target_i : head.pc + XLEN'(4);
        end
      end

      // Everything younger than a mispredicted branch is wrong-path, including a same-cycle push.
      if (do_pop && mispred) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
        if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        case ({do_push, do_pop})
          2'b10:   count <= count + COUNT_ONE;
          2'b01:   count <= count - COUNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_queue.sv
// Self-checking bench for branch_queue: a reference queue model feeds an expected
// result queue each cycle, plus directed scenario checks against fixed values.
module tb_branch_queue;
  import mmm_pkg::*;

  localparam int RW = 100;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [RW-1:0] exp_q[$];
  bq_entry_t     mq[$];

  branch_queue_if #(.DEPTH_BITS(3)) bq ();

  branch_queue #(.DEPTH_BITS(3)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bq   (bq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // One clock: model predicts the registered result, DUT is stepped, scoreboard compares.
  task automatic cycle(input logic r, input logic fl, input logic pv, input logic [31:0] ppc,
                       input logic pt, input logic [29:0] ptg, input logic ev,
                       input logic et, input logic [31:0] etg);
    logic bv, del, mp, uf, pop, push, mis;
    logic [31:0] rpc, rtg, rdir;
    logic [RW-1:0] got, want;
    bq_entry_t e;
    bv = 0; del = 0; mp = 0; uf = 0; rpc = 0; rtg = 0; rdir = 0; mis = 0;
    if (r || fl) begin
      mq.delete();
    end else begin
      pop  = ev && (mq.size() != 0);
      push = pv && (mq.size() != 8);
      uf   = ev && (mq.size() == 0);
      if (pop) begin
        e = mq[0];
        mis = (e.taken != et) || (e.taken && et && (e.target != etg[31:2]));
        if (et) begin
          bv = 1; rpc = e.pc; rtg = etg;
        end else if (e.taken) begin
          bv = 1; del = 1; rpc = e.pc;
        end
        if (mis) begin
          mp = 1; rdir = et ? etg : e.pc + 32'd4;
        end
      end
      if (pop && mis) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back('{pc: ppc, taken: pt, target: ptg});
      end
    end
    exp_q.push_back({bv, del, rpc, rtg, mp, rdir, uf});

    rst = r; bq.flush_i = fl; bq.pred_valid_i = pv; bq.pred_pc_i = ppc;
    bq.pred_taken_i = pt; bq.pred_target_i = ptg; bq.exe_valid_i = ev;
    bq.exe_taken_i = et; bq.exe_target_i = etg;
    @(posedge clk);
    #1;
    rst = 0; bq.flush_i = 0; bq.pred_valid_i = 0; bq.exe_valid_i = 0;

    got = {bq.btb_valid_o, bq.btb_del_entry_o, bq.btb_res_o, bq.mispredict_o,
           bq.redirect_pc_o, bq.underflow_o};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty got=%h exp=none", got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        failures++;
        $display("FAIL result got=%h exp=%h", got, want);
      end
    end
    checks++;
    if ((bq.count_o !== 4'(mq.size())) || (bq.full_o !== (mq.size() == 8)) ||
        (bq.empty_o !== (mq.size() == 0))) begin
      failures++;
      $display("FAIL occupancy got=%0d/%b/%b exp=%0d", bq.count_o, bq.full_o, bq.empty_o, mq.size());
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push(input logic [31:0] pc, input logic t, input logic [29:0] tg);
    cycle(0, 0, 1, pc, t, tg, 0, 0, 0);
  endtask

  task automatic pop(input logic t, input logic [31:0] tg);
    cycle(0, 0, 0, 0, 0, 0, 1, t, tg);
  endtask

  task automatic pop_correct();
    bq_entry_t e;
    e = mq[0];
    pop(e.taken, {e.target, 2'b00});
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bq.empty_o !== 1'b1 || bq.full_o !== 1'b0 || bq.count_o !== 4'd0 ||
        bq.mispredict_o !== 1'b0 || bq.btb_valid_o !== 1'b0 || bq.redirect_pc_o !== 32'd0) begin
      failures++;
      $display("FAIL reset_state got=e%b f%b c%0d m%b v%b exp=e1 f0 c0 m0 v0",
               bq.empty_o, bq.full_o, bq.count_o, bq.mispredict_o, bq.btb_valid_o);
    end
  endtask

  task automatic test_correct();
    push(32'h100, 1, 30'(32'h200 >> 2));
    pop(1, 32'h200);
    checks++;
    if (bq.btb_valid_o !== 1'b1 || bq.btb_del_entry_o !== 1'b0 || bq.btb_res_o.pc !== 32'h100 ||
        bq.btb_res_o.target !== 32'h200 || bq.mispredict_o !== 1'b0 || bq.count_o !== 4'd0) begin
      failures++;
      $display("FAIL correct_pred got=v%b d%b pc=%h tg=%h m%b c%0d exp=v1 d0 pc=100 tg=200 m0 c0",
               bq.btb_valid_o, bq.btb_del_entry_o, bq.btb_res_o.pc, bq.btb_res_o.target,
               bq.mispredict_o, bq.count_o);
    end
  endtask

  task automatic test_false_taken();
    push(32'h104, 1, 30'h40);
    pop(0, 32'h0);
    checks++;
    if (bq.btb_valid_o !== 1'b1 || bq.btb_del_entry_o !== 1'b1 || bq.mispredict_o !== 1'b1 ||
        bq.redirect_pc_o !== 32'h108 || bq.empty_o !== 1'b1) begin
      failures++;
      $display("FAIL false_taken got=v%b d%b m%b rd=%h e%b exp=v1 d1 m1 rd=108 e1",
               bq.btb_valid_o, bq.btb_del_entry_o, bq.mispredict_o, bq.redirect_pc_o, bq.empty_o);
    end
  endtask

  task automatic test_wrong_target();
    push(32'h110, 1, 30'(32'h300 >> 2));
    push(32'h114, 0, 30'h0);
    push(32'h118, 0, 30'h0);
    cycle(0, 0, 1, 32'h11c, 0, 30'h0, 1, 1, 32'h400);
    checks++;
    if (bq.mispredict_o !== 1'b1 || bq.redirect_pc_o !== 32'h400 || bq.count_o !== 4'd0) begin
      failures++;
      $display("FAIL wrong_target got=m%b rd=%h c%0d exp=m1 rd=400 c0",
               bq.mispredict_o, bq.redirect_pc_o, bq.count_o);
    end
    idle();
    checks++;
    if (bq.mispredict_o !== 1'b0 || bq.count_o !== 4'd0) begin
      failures++;
      $display("FAIL mispredict_pulse got=m%b c%0d exp=m0 c0", bq.mispredict_o, bq.count_o);
    end
  endtask

  task automatic test_full_wrap();
    logic [31:0] pcs [8];
    for (int i = 0; i < 8; i++) push(32'h1000 + 32'(4 * i), 1, 30'(32'h2000 + 32'(8 * i)) >> 0);
    checks++;
    if (bq.full_o !== 1'b1 || bq.count_o !== 4'd8) begin
      failures++;
      $display("FAIL full got=f%b c%0d exp=f1 c8", bq.full_o, bq.count_o);
    end
    cycle(0, 0, 1, 32'h1100, 1, 30'h5, 1, 1, {30'h2000, 2'b00});
    checks++;
    if (bq.count_o !== 4'd7 || bq.btb_res_o.pc !== 32'h1000) begin
      failures++;
      $display("FAIL push_while_full got=c%0d pc=%h exp=c7 pc=1000", bq.count_o, bq.btb_res_o.pc);
    end
    push(32'h1104, 1, 30'h777);
    for (int i = 0; i < 7; i++) pcs[i] = 32'h1004 + 32'(4 * i);
    pcs[7] = 32'h1104;
    for (int i = 0; i < 8; i++) begin
      pop_correct();
      checks++;
      if (bq.btb_res_o.pc !== pcs[i] || bq.mispredict_o !== 1'b0) begin
        failures++;
        $display("FAIL fifo_order[%0d] got=pc=%h m%b exp=pc=%h m0", i, bq.btb_res_o.pc,
                 bq.mispredict_o, pcs[i]);
      end
    end
    checks++;
    if (bq.empty_o !== 1'b1) begin
      failures++;
      $display("FAIL drained got=e%b exp=e1", bq.empty_o);
    end
  endtask

  task automatic test_underflow_flush();
    pop(1, 32'h500);
    checks++;
    if (bq.underflow_o !== 1'b1 || bq.btb_valid_o !== 1'b0 || bq.mispredict_o !== 1'b0) begin
      failures++;
      $display("FAIL underflow got=u%b v%b m%b exp=u1 v0 m0", bq.underflow_o, bq.btb_valid_o,
               bq.mispredict_o);
    end
    for (int i = 0; i < 5; i++) push(32'h2000 + 32'(4 * i), 0, 30'h0);
    checks++;
    if (bq.count_o !== 4'd5) begin
      failures++;
      $display("FAIL pre_flush_count got=%0d exp=5", bq.count_o);
    end
    cycle(0, 1, 1, 32'h3000, 1, 30'h1, 1, 1, 32'h900);
    checks++;
    if (bq.count_o !== 4'd0 || bq.btb_valid_o !== 1'b0 || bq.mispredict_o !== 1'b0 ||
        bq.underflow_o !== 1'b0 || bq.redirect_pc_o !== 32'd0 || bq.btb_res_o !== '0) begin
      failures++;
      $display("FAIL flush got=c%0d v%b m%b u%b rd=%h exp=c0 v0 m0 u0 rd=0", bq.count_o,
               bq.btb_valid_o, bq.mispredict_o, bq.underflow_o, bq.redirect_pc_o);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) push(32'h4000 + 32'(4 * i), 1, 30'h10);
    cycle(1, 0, 1, 32'h5000, 0, 30'h0, 1, 0, 32'h0);
    checks++;
    if (bq.empty_o !== 1'b1 || bq.mispredict_o !== 1'b0 || bq.btb_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got=e%b m%b v%b exp=e1 m0 v0", bq.empty_o, bq.mispredict_o,
               bq.btb_valid_o);
    end
  endtask

  task automatic test_random();
    bq_entry_t e;
    logic ev, et;
    logic [31:0] etg;
    for (int n = 0; n < 400; n++) begin
      ev = ($urandom_range(0, 1) == 1);
      et = 0; etg = 32'($urandom);
      if (ev && mq.size() != 0) begin
        e = mq[0];
        et = e.taken; etg = e.taken ? {e.target, 2'b00} : etg;
        if ($urandom_range(0, 7) == 0) et = ~et;
        else if (e.taken && $urandom_range(0, 7) == 0) etg = etg ^ 32'h10;
      end
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 2) != 0), {$urandom_range(0, 32'hffff), 2'b00},
            ($urandom_range(0, 1) == 1), 30'($urandom_range(0, 255)), ev, et, etg);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1; bq.flush_i = 0; bq.pred_valid_i = 0; bq.pred_pc_i = 0; bq.pred_taken_i = 0;
    bq.pred_target_i = 0; bq.exe_valid_i = 0; bq.exe_taken_i = 0; bq.exe_target_i = 0;
    #1;
    test_reset();
    test_correct();
    test_false_taken();
    test_wrong_target();
    test_full_wrap();
    test_underflow_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_queue.md
BRANCH_QUEUE -- requirements
Module: branch_queue

Interface
REQ-001 SHALL have parameter DEPTH_BITS, default 3, meaning queue depth is 2**DEPTH_BITS in-flight predictions.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clk_i, input, 1 bit, meaning clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit, meaning synchronous active-high reset.
REQ-005 SHALL have port flush_i, input, 1 bit, meaning synchronous pipeline flush.
REQ-006 SHALL have port pred_valid_i, input, 1 bit, meaning push request from fetch.
REQ-007 SHALL have port pred_pc_i, input, XLEN bits, meaning fetch PC of the predicted instruction.
REQ-008 SHALL have port pred_taken_i, input, 1 bit, meaning predicted taken (the BTB hit).
REQ-009 SHALL have port pred_target_i, input, XLEN-OFFSET bits, meaning predicted target (the BTB target).
REQ-010 SHALL have port exe_valid_i, input, 1 bit, meaning in-order branch resolution from execute.
REQ-011 SHALL have port exe_taken_i, input, 1 bit, meaning actual outcome.
REQ-012 SHALL have port exe_target_i, input, XLEN bits, meaning actual target.
REQ-013 SHALL have port full_o, output, 1 bit, meaning queue full.
REQ-014 SHALL have port empty_o, output, 1 bit, meaning queue empty.
REQ-015 SHALL have port count_o, output, DEPTH_BITS+1 bits, meaning occupancy.
REQ-016 SHALL have port btb_valid_o, output, 1 bit, meaning BTB update strobe.
REQ-017 SHALL have port btb_del_entry_o, output, 1 bit, meaning BTB entry delete.
REQ-018 SHALL have port btb_res_o, output, resolution_t, meaning pc/target for the BTB write.
REQ-019 SHALL have port mispredict_o, output, 1 bit, meaning one-cycle redirect pulse.
REQ-020 SHALL have port redirect_pc_o, output, XLEN bits, meaning correct next PC.
REQ-021 SHALL have port underflow_o, output, 1 bit, meaning resolution arrived with an empty queue.

Function
REQ-022 SHALL push {pred_pc_i, pred_taken_i, pred_target_i} when pred_valid_i and !full_o; pushes while full are dropped, even if a pop occurs in the same cycle (no bypass).
REQ-023 SHALL pop the oldest entry when exe_valid_i and !empty_o; exe_valid_i while empty_o is ignored, sets underflow_o for one cycle, and is not bypassed by a same-cycle push.
REQ-024 SHALL combine wrapping DEPTH_BITS-bit read/write pointers with count_o; full_o = (count_o == 2**DEPTH_BITS), empty_o = (count_o == 0), both combinational from registered count.
REQ-025 SHALL flag a misprediction on pop when taken differs (pred_taken != exe_taken_i), or when both are taken and pred_target != exe_target_i[XLEN-1:OFFSET].
REQ-026 SHALL register all result outputs, which are valid the cycle after the pop edge (latency 1); outputs are zero in cycles with no pop.
REQ-027 SHALL drive BTB outputs on pop: if exe_taken_i, btb_valid_o=1, btb_del_entry_o=0, btb_res_o={entry pc, exe_target_i}; if pred_taken and !exe_taken_i, btb_valid_o=1 and btb_del_entry_o=1; if neither is taken, btb_valid_o=0.
REQ-028 SHALL drive redirect_pc_o on a mispredicting pop: exe_target_i if exe_taken_i, else entry pc + 4 (modulo 2**XLEN); mispredict_o=1 for exactly one cycle.
REQ-029 SHALL clear the queue (pointers and count to 0) at the edge of a mispredicting pop; a same-cycle push is discarded as wrong-path.
REQ-030 SHALL, on flush_i, clear the queue and ignore the same-cycle push and pop; result outputs are 0 next cycle; rst_i has priority over flush_i.

Reset
REQ-031 SHALL, on rst_i, set pointers and count to 0; full_o=0, empty_o=1, count_o=0; btb_valid_o, btb_del_entry_o, mispredict_o, underflow_o=0; btb_res_o and redirect_pc_o='0; storage contents are don't-care.
REQ-032 SHALL, on rst_i asserted mid-operation, discard all in-flight entries and suppress any pending result on the following cycle.

Structure
REQ-033 SHALL take XLEN, OFFSET and resolution_t from mmm_pkg; the new queue entry typedef bq_entry_t {pc, taken, target} SHALL be added to mmm_pkg.
REQ-034 SHALL keep storage and compare inline in branch_queue; no sub-module is required.

Verification (XLEN=32, OFFSET=2, DEPTH_BITS=3)
REQ-035 SHALL cover correct prediction: push pc=0x100, taken, target=0x200>>2; resolve taken, 0x200 -> next cycle btb_valid_o=1, del=0, res={0x100,0x200}, mispredict_o=0, count_o=0.
REQ-036 SHALL cover a false-taken prediction: push pc=0x104, taken; resolve not taken -> btb_valid_o=1, del=1, mispredict_o=1, redirect_pc_o=0x108, queue cleared.
REQ-037 SHALL cover wrong target: push 3 entries, the first predicting 0x300; resolve the first taken to 0x400 -> mispredict_o=1, redirect_pc_o=0x400, count_o=0 next cycle, same-cycle push dropped.
REQ-038 SHALL cover full/wrap: 8 pushes -> full_o=1; a 9th push plus a same-cycle pop -> count_o=7; then 8 in-order correct pops across the pointer wrap, with FIFO order preserved.
REQ-039 SHALL cover underflow and flush: exe_valid_i on an empty queue -> underflow_o=1 and no BTB write; flush_i with count_o=5 plus a same-cycle pop -> count_o=0, all outputs 0.
REQ-040 SHALL cover reset mid-operation: rst_i with count_o=4 and a pop pending -> next cycle empty_o=1, mispredict_o=0, btb_valid_o=0.
